ffsync: RTL and testbench



---
 rtl/ffsync.sv | 61 ++++++
 tb/tb_ffsync.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ffsync.sv
// ffsync: a capture register followed by a chain of S retiming flops for a
// W-bit word. It resamples signals that change asynchronously to clk and
// adds a fixed latency of S+1 edges to in-domain signals.
// When EVLD=1, the capture register loads only on cycles with vld=1.
module ffsync #(
    parameter int          W    = 8,
    parameter logic [W-1:0] INIT = '0,
    parameter bit          EVLD = 1'b0,
    parameter int          S    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         vld,
    output logic [W-1:0] q
);

    // Reject illegal widths and depths at elaboration time.
    generate
        if (W < 1) begin : g_bad_w
            $error("ffsync: W must be >= 1");
        end
        if (S < 1) begin : g_bad_s
            $error("ffsync: S must be >= 1");
        end
    endgenerate

    logic [W-1:0] cap;

    // Keep the retiming flops as distinct registers placed next to each
    // other, so their full metastability settling time is preserved.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [W-1:0] s [1:S];

    // Capture register. It loads every cycle, or only when vld=1 if EVLD is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap <= INIT;
        end else if (!EVLD || vld) begin
            cap <= d;
        end
    end

    // Synchronizer chain. It shifts on every non-reset edge; vld never gates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= S; i++) begin
                s[i] <= INIT;
            end
        end else begin
            s[1] <= cap;
            for (int i = 2; i <= S; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    // The output comes straight from the last flop, with no logic after it.
    assign q = s[S];

endmodule

// File: tb/tb_ffsync.sv
// Self-checking bench for ffsync. Three instances share one stimulus stream:
//   a: INIT=A5, EVLD=0, S=3
//   b: INIT=00, EVLD=0, S=1
//   c: INIT=A5, EVLD=1, S=3
// The reference model records what each capture register holds after every
// edge. After edge n, q equals the value captured S edges earlier, or INIT
// if a reset was sampled at any edge in between.
module tb_ffsync;

    localparam int MAXN = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       vld;
    logic [7:0] q_a, q_b, q_c;

    ffsync #(.W(8), .INIT(8'hA5), .EVLD(1'b0), .S(3)) dut_a (
        .clk(clk), .rst(rst), .d(d), .vld(vld), .q(q_a));
    ffsync #(.W(8), .INIT(8'h00), .EVLD(1'b0), .S(1)) dut_b (
        .clk(clk), .rst(rst), .d(d), .vld(vld), .q(q_b));
    ffsync #(.W(8), .INIT(8'hA5), .EVLD(1'b1), .S(3)) dut_c (
        .clk(clk), .rst(rst), .d(d), .vld(vld), .q(q_c));

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    int         n          = -1;
    logic       rst_hist [0:MAXN];
    logic [7:0] cap_a [0:MAXN];
    logic [7:0] cap_b [0:MAXN];
    logic [7:0] cap_c [0:MAXN];

    // Expected q after edge k for a chain of depth sd, reset value init.
    function automatic logic [7:0] exp_q(input int cfg, input int sd,
                                         input logic [7:0] init, input int k);
        int lo;
        lo = k - sd + 1;
        if (lo < 0) lo = 0;
        for (int e = lo; e <= k; e++) begin
            if (rst_hist[e]) return init;
        end
        case (cfg)
            0:       return cap_a[k-sd];
            1:       return cap_b[k-sd];
            default: return cap_c[k-sd];
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s edge=%0d observed=%02h expected=%02h", tag, n, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, update the model, then check all three DUTs.
    task automatic step(input logic [7:0] dv, input logic vv, input logic rv);
        @(negedge clk);
        d = dv; vld = vv; rst = rv;
        @(posedge clk);
        n++;
        if (n > MAXN) begin
            $display("FAIL model_overflow edge=%0d observed=%0d required<=%0d", n, n, MAXN);
            $fatal(1, "history overflow");
        end
        rst_hist[n] = rv;
        cap_a[n] = rv ? 8'hA5 : dv;
        cap_b[n] = rv ? 8'h00 : dv;
        if (rv)      cap_c[n] = 8'hA5;
        else if (vv) cap_c[n] = dv;
        else         cap_c[n] = (n == 0) ? 8'hxx : cap_c[n-1];
        #1;
        check("q_a", q_a, exp_q(0, 3, 8'hA5, n));
        check("q_b", q_b, exp_q(1, 1, 8'h00, n));
        check("q_c", q_c, exp_q(2, 3, 8'hA5, n));
    endtask

    initial begin
        rst = 1'b1; d = 8'hFF; vld = 1'b0;

        // Reset held for 2 cycles with d=FF, then release.
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(8'hFF, 1'b1, 1'b0);

        // Latency: step d from 00 to 3C.
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h3C, 1'b1, 1'b0);

        // Streaming 1..20 on consecutive cycles.
        for (int i = 1; i <= 20; i++) step(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b0);

        // Valid gating: 11 captured, 22/33 must not pass on EVLD=1, then 44.
        step(8'h11, 1'b1, 1'b0);
        step(8'h22, 1'b0, 1'b0);
        step(8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h33, 1'b0, 1'b0);
        step(8'h44, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h44, 1'b0, 1'b0);

        // Mid-stream reset with 55 in flight.
        step(8'h55, 1'b1, 1'b0);
        step(8'h66, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(8'h77, 1'b1, 1'b0);
        check("q_a_post_rst", q_a, 8'h77);
        check("q_c_post_rst", q_c, 8'h77);

        // Randomized traffic with occasional resets and sparse valids.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
